// File: rtl/fc_rx_deframer.sv
// Fibre Channel receive deframer: delimits SOF..EOF frames from the PCS word
// stream and emits them as Avalon-ST packets with length/abort error flags.
module fc_rx_deframer #(
   parameter int MAX_WORDS = 537,
   parameter int MIN_WORDS = 9
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] rx_data,
   input  logic [3:0]  rx_datak,
   input  logic        rx_valid,
   input  logic        rx_sync,
   output logic [31:0] out_data,
   output logic        out_valid,
   output logic        out_startofpacket,
   output logic        out_endofpacket,
   output logic [1:0]  out_error,
   output logic [15:0] frame_count,
   output logic [15:0] error_count
);

   localparam int CW = $clog2(MAX_WORDS + 2);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_WORDS);

   typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

   state_t        state;
   logic [31:0]   hold_data;
   logic          hold_sop;
   logic          hold_eof;
   logic          hold_short;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;

   logic [7:0] b3, b2, b1, b0;
   logic       is_os, is_sof, is_eof, is_data, is_prim, acc;

   assign b3 = rx_data[31:24];
   assign b2 = rx_data[23:16];
   assign b1 = rx_data[15:8];
   assign b0 = rx_data[7:0];

   assign acc     = rx_valid & rx_sync;
   assign is_os   = (rx_datak == 4'b1000) && (b3 == 8'hBC);
   assign is_sof  = is_os && (b2 == 8'hB5) && (b1 == b0) &&
                    ((b0 == 8'h56) || (b0 == 8'h36) || (b0 == 8'h58));
   assign is_eof  = is_os && (b1 == b0) &&
                    ((b2 == 8'h95) || (b2 == 8'hB5) ||
                     (b2 == 8'h8A) || (b2 == 8'hAA)) &&
                    ((b0 == 8'h75) || (b0 == 8'hD5) || (b0 == 8'hF5));
   assign is_data = (rx_datak == 4'b0000);
   assign is_prim = !is_data && !is_sof && !is_eof;
   assign cnt_nx  = cnt + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         hold_data         <= '0;
         hold_sop          <= 1'b0;
         hold_eof          <= 1'b0;
         hold_short        <= 1'b0;
         cnt               <= '0;
         out_data          <= '0;
         out_valid         <= 1'b0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_error         <= 2'b00;
      end else begin
         out_valid         <= 1'b0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_error         <= 2'b00;
         // A held EOF leaves unconditionally; state is already IDLE here
         if (hold_eof) begin
            out_valid       <= 1'b1;
            out_data        <= hold_data;
            out_endofpacket <= 1'b1;
            out_error       <= {1'b0, hold_short};
            hold_eof        <= 1'b0;
         end
         unique case (state)
            IDLE, DISCARD: begin
               if (!rx_sync) begin
                  state <= IDLE;
               end else if (acc && is_sof) begin
                  hold_data <= rx_data;
                  hold_sop  <= 1'b1;
                  cnt       <= CW'(1);
                  state     <= FRAME;
               end else if (acc && is_eof) begin
                  state <= IDLE;
               end
            end
            FRAME: begin
               if (!rx_sync || (rx_valid && is_prim)) begin
                  out_valid         <= 1'b1;
                  out_data          <= hold_data;
                  out_startofpacket <= hold_sop;
                  out_endofpacket   <= 1'b1;
                  out_error         <= 2'b10;
                  state             <= IDLE;
               end else if (rx_valid) begin
                  out_valid         <= 1'b1;
                  out_data          <= hold_data;
                  out_startofpacket <= hold_sop;
                  if (is_sof) begin
                     out_endofpacket <= 1'b1;
                     out_error       <= 2'b10;
                     hold_data       <= rx_data;
                     hold_sop        <= 1'b1;
                     cnt             <= CW'(1);
                  end else if (is_eof) begin
                     hold_data  <= rx_data;
                     hold_sop   <= 1'b0;
                     hold_eof   <= 1'b1;
                     hold_short <= (cnt_nx < MIN_C) || (cnt_nx > MAX_C);
                     state      <= IDLE;
                  end else if (cnt_nx > MAX_C) begin
                     out_endofpacket <= 1'b1;
                     out_error       <= 2'b01;
                     state           <= DISCARD;
                  end else begin
                     hold_data <= rx_data;
                     hold_sop  <= 1'b0;
                     cnt       <= cnt_nx;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= '0;
         error_count <= '0;
      end else if (out_valid && out_endofpacket) begin
         if (out_error == 2'b00) begin
            if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
         end else begin
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
         end
      end
   end

endmodule
